// File: rtl/hit_burst_monitor_if.sv
// Hit burst monitor bus: detector hit/clr in, alarm and counters out.
// Master drives hit/clr; the monitor is the slave.
interface hit_burst_monitor_if #(
  parameter int CNT_W = 8
);
  logic             hit;
  logic             clr;
  logic             alarm;
  logic             win_active;
  logic [CNT_W-1:0] win_hits;
  logic [CNT_W-1:0] total_hits;

  modport master (
    output hit,
    output clr,
    input  alarm,
    input  win_active,
    input  win_hits,
    input  total_hits
  );

  modport slave (
    input  hit,
    input  clr,
    output alarm,
    output win_active,
    output win_hits,
    output total_hits
  );
endinterface

// File: rtl/hit_burst_monitor.sv
// Burst alarm over a fixed window of 1101-detector hits.
// Define HIT_BURST_AUTOCLR_EN to let ALARM expire with its window.
module hit_burst_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 3
) (
  input  logic               clk,
  input  logic               rst,
  hit_burst_monitor_if.slave bus
);

  localparam int WC_W = $clog2(WINDOW);
  localparam logic [WC_W-1:0] WC_INIT = WC_W'(WINDOW - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
  localparam bit ONE_TRIP = (THRESH == 1);
`ifdef HIT_BURST_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALARM = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             alarm_q, alarm_d;
  logic             win_active_q, win_active_d;
  logic [CNT_W-1:0] win_hits_q, win_hits_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;

  logic [CNT_W-1:0] nh;
  logic             trip;
  logic             expire;

  assign nh = (win_hits_q == CNT_MAX) ? CNT_MAX
            : win_hits_q + CNT_W'(bus.hit);
  assign trip = (nh >= THR);
  // last window cycle: wcnt lands on zero at this edge
  assign expire = (wcnt_q <= WC_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      alarm_q      <= 1'b0;
      win_active_q <= 1'b0;
      win_hits_q   <= '0;
      total_q      <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      alarm_q      <= alarm_d;
      win_active_q <= win_active_d;
      win_hits_q   <= win_hits_d;
      total_q      <= total_d;
      wcnt_q       <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.hit) state_d = ONE_TRIP ? ALARM : COUNT;
        end
        COUNT: begin
          if (trip)        state_d = ALARM;
          else if (expire) state_d = IDLE;
        end
        ALARM: begin
`ifdef HIT_BURST_AUTOCLR_EN
          if (expire) state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    win_hits_d = win_hits_q;
    total_d    = total_q;
    wcnt_d     = wcnt_q;
    if (bus.clr) begin
      win_hits_d = '0;
      total_d    = '0;
      wcnt_d     = '0;
    end else begin
      if (bus.hit && total_q != CNT_MAX) total_d = total_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.hit) begin
            win_hits_d = CNT_W'(1);
            wcnt_d     = WC_INIT;
          end
        end
        COUNT: begin
          win_hits_d = nh;
          wcnt_d     = expire ? '0 : wcnt_q - 1'b1;
        end
        ALARM: begin
`ifdef HIT_BURST_AUTOCLR_EN
          wcnt_d = expire ? '0 : wcnt_q - 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alarm_d      = (state_d == ALARM);
    win_active_d = (state_d == COUNT)
                || (AUTOCLR && state_d == ALARM && wcnt_d != '0);
  end

  assign bus.alarm      = alarm_q;
  assign bus.win_active = win_active_q;
  assign bus.win_hits   = win_hits_q;
  assign bus.total_hits = total_q;

endmodule

// File: tb/tb_hit_burst_monitor.sv
// Directed bench for hit_burst_monitor, WINDOW=8 THRESH=3 CNT_W=8.
// Honours HIT_BURST_AUTOCLR_EN when defined for the build.
module tb_hit_burst_monitor;

  localparam int CNT_W  = 8;
  localparam int WINDOW = 8;
  localparam int THRESH = 3;
`ifdef HIT_BURST_AUTOCLR_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic hit_drv = 1'b0;
  logic use_det = 1'b0;
  logic din     = 1'b0;

  hit_burst_monitor_if #(.CNT_W(CNT_W)) bif ();

  hit_burst_monitor #(
    .CNT_W (CNT_W),
    .WINDOW(WINDOW),
    .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bif)
  );

  always #5 clk = ~clk;

  // upstream 1101 overlapping Mealy detector
  typedef enum logic [1:0] {D0, D1, D11, D110} det_e;
  det_e ds;
  logic det_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds <= D0;
    else begin
      case (ds)
        D0:      ds <= din ? D1  : D0;
        D1:      ds <= din ? D11 : D0;
        D11:     ds <= din ? D11 : D110;
        D110:    ds <= din ? D1  : D0;
        default: ds <= D0;
      endcase
    end
  end

  assign det_out = (ds == D110) && din;
  assign bif.hit = use_det ? det_out : hit_drv;

  typedef struct {
    string      tag;
    logic       tot_only;
    logic       alarm;
    logic       wa;
    logic [7:0] wh;
    logic [7:0] th;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string tag, input logic tot_only,
                      input logic a, input logic w,
                      input logic [7:0] wh, input logic [7:0] th);
    exp_t e;
    e.tag = tag; e.tot_only = tot_only;
    e.alarm = a; e.wa = w; e.wh = wh; e.th = th;
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got 0 entries exp 1");
    end else begin
      e = q.pop_front();
      checks++;
      assert (bif.total_hits === e.th) else begin
        errors++;
        $error("FAIL %s total_hits got %0d exp %0d",
               e.tag, bif.total_hits, e.th);
      end
      if (!e.tot_only) begin
        checks++;
        assert (bif.alarm === e.alarm) else begin
          errors++;
          $error("FAIL %s alarm got %0d exp %0d",
                 e.tag, bif.alarm, e.alarm);
        end
        checks++;
        assert (bif.win_active === e.wa) else begin
          errors++;
          $error("FAIL %s win_active got %0d exp %0d",
                 e.tag, bif.win_active, e.wa);
        end
        checks++;
        assert (bif.win_hits === e.wh) else begin
          errors++;
          $error("FAIL %s win_hits got %0d exp %0d",
                 e.tag, bif.win_hits, e.wh);
        end
      end
    end
  endtask

  // drive at negedge, sample 1 ns after the next rising edge
  task automatic cyc(input logic h, input logic c,
                     input logic a, input logic w,
                     input logic [7:0] wh, input logic [7:0] th,
                     input string tag, input logic tot_only = 1'b0);
    hit_drv = h;
    bif.clr = c;
    push(tag, tot_only, a, w, wh, th);
    @(posedge clk);
    #1;
    chk();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int stream [10];
    logic [7:0] n;
    stream = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    bif.clr = 1'b0;

    // reset held with hit toggling
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, "rst_hold0");
    cyc(0, 0, 0, 0, 0, 0, "rst_hold1");
    cyc(1, 0, 0, 0, 0, 0, "rst_hold2");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, "rst_rel");

    // burst trip on the final window cycle
    cyc(1, 0, 0, 1, 1, 1, "burst_c0");
    for (int k = 1; k <= 6; k++) begin
      n = (k >= 3) ? 8'd2 : 8'd1;
      cyc(k == 3, 0, 0, 1, n, n, "burst_win");
    end
    cyc(1, 0, 1, 0, 3, 3, "burst_last");
    cyc(0, 1, 0, 0, 0, 0, "burst_clr");

    // expiry and reopen
    cyc(1, 0, 0, 1, 1, 1, "exp_c0");
    for (int k = 1; k <= 6; k++) begin
      n = (k >= 5) ? 8'd2 : 8'd1;
      cyc(k == 5, 0, 0, 1, n, n, "exp_win");
    end
    cyc(0, 0, 0, 0, 2, 2, "exp_close");
    cyc(1, 0, 0, 1, 1, 3, "exp_reopen");
    cyc(0, 1, 0, 0, 0, 0, "exp_clr");

    // sticky vs auto-clear
    cyc(1, 0, 0, 1, 1, 1, "stk_c0");
    cyc(1, 0, 0, 1, 2, 2, "stk_c1");
    cyc(1, 0, 1, AC, 3, 3, "stk_trip");
    for (int k = 3; k <= 12; k++) begin
      cyc(0, 0, AC ? (k < 7) : 1'b1, AC ? (k < 7) : 1'b0,
          3, 3, "stk_hold");
    end
    cyc(0, 1, 0, 0, 0, 0, "stk_clr");

    // clr colliding with a hit while in ALARM
    cyc(1, 0, 0, 1, 1, 1, "col_c0");
    cyc(1, 0, 0, 1, 2, 2, "col_c1");
    cyc(1, 0, 1, AC, 3, 3, "col_trip");
    cyc(1, 0, 1, AC, 3, 4, "col_c3");
    cyc(1, 0, 1, AC, 3, 5, "col_c4");
    cyc(1, 1, 0, 0, 0, 0, "col_clr_hit");
    cyc(0, 0, 0, 0, 0, 0, "col_after");
    cyc(1, 0, 0, 1, 1, 1, "col_next");
    cyc(0, 1, 0, 0, 0, 0, "col_clr");

    // serial 1101101101 through the detector
    use_det = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din = stream[k][0];
      n = (k >= 9) ? 8'd3 : (k >= 6) ? 8'd2 : (k >= 3) ? 8'd1 : 8'd0;
      cyc(0, 0, k == 9,
          (k >= 3 && k <= 8) || (k == 9 && AC),
          n, n, "chain");
    end
    din = 1'b0;
    use_det = 1'b0;
    cyc(0, 1, 0, 0, 0, 0, "chain_clr");

    // total_hits saturation
    for (int i = 0; i < 300; i++) begin
      n = (i >= 254) ? 8'd255 : 8'(i + 1);
      cyc(1, 0, 0, 0, 0, n, "sat", 1'b1);
    end
    cyc(0, 0, 0, 0, 0, 255, "sat_hold", 1'b1);

    // asynchronous reset mid-cycle
    hit_drv = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 1'b0, 0, 0, 0, 0);
    chk();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
